// File: rtl/sdf_stage_ctrl_if.sv
// Sample handshake and stage-control bundle between an SDF stage datapath and its sequencer.
// The master drives the sample qualifiers; the slave (sequencer) returns the control word.
interface sdf_stage_ctrl_if #(
  parameter int unsigned AW = 5
) ();

  logic          in_valid;
  logic          in_last;
  logic [1:0]    state;
  logic [AW-1:0] tw_addr;
  logic          out_valid;
  logic          busy;
  logic          frame_done;
  logic          err;

  modport master (
    output in_valid,
    output in_last,
    input  state,
    input  tw_addr,
    input  out_valid,
    input  busy,
    input  frame_done,
    input  err
  );

  modport slave (
    input  in_valid,
    input  in_last,
    output state,
    output tw_addr,
    output out_valid,
    output busy,
    output frame_done,
    output err
  );

endinterface

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF stage: counts accepted samples, selects fill/butterfly/twiddle
// mode with zero-cycle control latency, and drains the delay line at end of stream.
module sdf_stage_ctrl #(
  parameter int unsigned HALF = 32,
  parameter int unsigned AW   = $clog2(HALF)
) (
  input  logic             clk,
  input  logic             rst_n,
  sdf_stage_ctrl_if.slave  s_if
);

  localparam int unsigned PW = AW + 1;

  localparam logic [PW-1:0] PC_HALF_M1 = PW'(HALF - 1);
  localparam logic [PW-1:0] PC_LAST    = PW'(2 * HALF - 1);
  localparam logic [AW-1:0] DC_LAST    = AW'(HALF - 1);

  localparam logic [1:0] MODE_FILL = 2'd0;
  localparam logic [1:0] MODE_BFLY = 2'd1;
  localparam logic [1:0] MODE_TWID = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } fsm_t;

  fsm_t          r_fsm;
  logic [PW-1:0] r_pc;
  logic [AW-1:0] r_dc;
  logic          r_err;

  logic          w_accept;
  logic          w_end;
  logic          w_proto_err;
  logic [1:0]    w_state;
  logic [AW-1:0] w_tw_addr;
  logic          w_out_valid;
  logic          w_busy;
  logic          w_frame_done;

  // Stream may only end on the last sample of a full 2*HALF block.
  always_comb begin
    w_accept    = s_if.in_valid && (r_fsm != S_DRAIN);
    w_end       = w_accept && s_if.in_last && (r_fsm == S_RUN) && (r_pc == PC_LAST);
    w_proto_err = (w_accept && s_if.in_last && !w_end) ||
                  (s_if.in_valid && (r_fsm == S_DRAIN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= S_IDLE;
      r_pc  <= '0;
      r_dc  <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_proto_err) begin
        r_err <= 1'b1;
      end
      case (r_fsm)
        S_IDLE: begin
          if (s_if.in_valid) begin
            r_pc  <= PW'(1);
            r_fsm <= S_FILL;
          end
        end
        S_FILL: begin
          if (s_if.in_valid) begin
            r_pc <= r_pc + PW'(1);
            if (r_pc == PC_HALF_M1) begin
              r_fsm <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (s_if.in_valid) begin
            r_pc <= r_pc + PW'(1);
            if (w_end) begin
              r_fsm <= S_DRAIN;
              r_dc  <= '0;
            end
          end
        end
        S_DRAIN: begin
          r_dc <= r_dc + AW'(1);
          if (r_dc == DC_LAST) begin
            r_fsm <= S_IDLE;
            r_pc  <= '0;
          end
        end
        default: begin
          r_fsm <= S_IDLE;
        end
      endcase
    end
  end

  // HALF is a power of two, so the pc MSB marks the butterfly half of a block.
  always_comb begin
    w_state      = MODE_FILL;
    w_tw_addr    = '0;
    w_out_valid  = 1'b0;
    w_busy       = (r_fsm != S_IDLE);
    w_frame_done = 1'b0;
    case (r_fsm)
      S_RUN: begin
        w_out_valid = s_if.in_valid;
        if (r_pc[AW]) begin
          w_state = MODE_BFLY;
        end else begin
          w_state   = MODE_TWID;
          w_tw_addr = r_pc[AW-1:0];
        end
      end
      S_DRAIN: begin
        w_state      = MODE_TWID;
        w_tw_addr    = r_dc;
        w_out_valid  = 1'b1;
        w_frame_done = (r_dc == DC_LAST);
      end
      default: begin
        w_state = MODE_FILL;
      end
    endcase
  end

  assign s_if.state      = w_state;
  assign s_if.tw_addr    = w_tw_addr;
  assign s_if.out_valid  = w_out_valid;
  assign s_if.busy       = w_busy;
  assign s_if.frame_done = w_frame_done;
  assign s_if.err        = r_err;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Self-checking bench for sdf_stage_ctrl: directed streams plus randomized traffic,
// compared each cycle against a sample-index reference model.
module tb_sdf_stage_ctrl;

  localparam int unsigned HALF = 32;
  localparam int unsigned AW   = 5;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // Reference model: samples accepted since stream start, drain progress, sticky error.
  int m_n     = 0;
  bit m_drain = 1'b0;
  int m_k     = 0;
  bit m_err   = 1'b0;

  sdf_stage_ctrl_if #(.AW(AW)) u_if ();

  sdf_stage_ctrl #(
    .HALF (HALF),
    .AW   (AW)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_if  (u_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (n=%0d drain=%0d k=%0d)",
             tag, obs, exp, m_n, m_drain, m_k);
    end
  endtask

  function automatic bit model_at_end();
    return !m_drain && (m_n >= int'(HALF)) && ((m_n % (2 * HALF)) == 2 * HALF - 1);
  endfunction

  task automatic check_all();
    int st, tw, ov, bz, fd, p;
    st = 0; tw = 0; ov = 0; bz = 0; fd = 0;
    if (m_drain) begin
      st = 2; tw = m_k; ov = 1; bz = 1; fd = (m_k == HALF - 1) ? 1 : 0;
    end else if (m_n > 0) begin
      bz = 1;
      if (m_n >= int'(HALF)) begin
        p  = m_n % (2 * HALF);
        ov = u_if.in_valid ? 1 : 0;
        if (p >= int'(HALF)) st = 1;
        else begin
          st = 2; tw = p;
        end
      end
    end
    chk("state",      32'(u_if.state),      32'(st));
    chk("tw_addr",    32'(u_if.tw_addr),    32'(tw));
    chk("out_valid",  32'(u_if.out_valid),  32'(ov));
    chk("busy",       32'(u_if.busy),       32'(bz));
    chk("frame_done", 32'(u_if.frame_done), 32'(fd));
    chk("err",        32'(u_if.err),        32'(m_err));
  endtask

  task automatic model_step(input bit v, input bit l);
    if (m_drain) begin
      if (v) m_err = 1'b1;
      m_k++;
      if (m_k == int'(HALF)) begin
        m_drain = 1'b0;
        m_n     = 0;
      end
    end else if (v) begin
      if (l && model_at_end()) begin
        m_drain = 1'b1;
        m_k     = 0;
        m_n     = 0;
      end else begin
        if (l) m_err = 1'b1;
        m_n++;
      end
    end
  endtask

  task automatic cyc(input bit v, input bit l);
    @(negedge clk);
    u_if.in_valid = v;
    u_if.in_last  = l;
    #1;
    check_all();
    @(posedge clk);
    model_step(v, l);
  endtask

  // Asserts reset mid-cycle and checks outputs drop immediately and stay low.
  task automatic do_reset();
    #2;
    check_all();
    rst_n = 1'b0;
    #1;
    m_n = 0; m_drain = 1'b0; m_k = 0; m_err = 1'b0;
    check_all();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      u_if.in_valid = ~u_if.in_valid;
      u_if.in_last  = u_if.in_valid;
      #1;
      check_all();
    end
    @(negedge clk);
    u_if.in_valid = 1'b0;
    u_if.in_last  = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic stream(input int nsamp, input int last_a, input int last_b,
                        input int gap_a, input int gap_b);
    for (int s = 0; s < nsamp; s++) begin
      cyc(1'b1, (s == last_a) || (s == last_b));
      if (s == gap_a || s == gap_b)
        for (int g = 0; g < 5; g++) cyc(1'b0, 1'b0);
    end
  endtask

  task automatic drain(input int ncyc, input bit v);
    for (int i = 0; i < ncyc; i++) cyc(v, 1'b0);
  endtask

  initial begin
    rst_n         = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_last  = 1'b0;
    #3;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single block, then confirm return to idle.
    stream(64, 63, -1, -1, -1);
    drain(HALF, 1'b0);
    cyc(1'b0, 1'b0);

    // Multi-block: twiddle phase appears on the second block.
    stream(128, 127, -1, -1, -1);
    drain(HALF, 1'b0);
    cyc(1'b0, 1'b0);

    // Stalls inside fill and inside run.
    stream(128, 127, -1, 10, 40);
    drain(HALF, 1'b0);

    // Misplaced in_last, then in_valid during drain.
    stream(64, 40, 63, -1, -1);
    drain(HALF, 1'b1);
    cyc(1'b0, 1'b0);

    // In_last on the final fill sample is an error and fill still ends.
    stream(64, 31, 63, -1, -1);
    drain(HALF, 1'b0);

    // Reset during drain at tw_addr=12, then a clean stream.
    do_reset();
    stream(64, 63, -1, -1, -1);
    drain(12, 1'b0);
    do_reset();
    stream(64, 63, -1, -1, -1);
    drain(HALF, 1'b0);
    cyc(1'b0, 1'b0);

    // Randomized traffic with periodic resets.
    for (int i = 0; i < 4000; i++) begin
      bit v, l;
      v = ($urandom_range(0, 3) != 0);
      if (v && model_at_end()) l = ($urandom_range(0, 2) != 0);
      else                     l = ($urandom_range(0, 150) == 0);
      cyc(v, l);
      if ((i % 997) == 996) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
